sd_dac_mc: RTL and testbench

SD_DAC_MC -- requirements
Module: sd_dac_mc

---
 rtl/sd_dac_mc.sv | 132 +++++++++++++
 tb/tb_sd_dac_mc.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_dac_mc.sv
// Multi-channel first/second-order sigma-delta DAC with a one-frame holding buffer.
// Define SD_DAC_MC_DITHER_EN to add one LSB of LFSR dither per channel.
module sd_dac_mc #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int OSR_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic                      order2,
    output logic [CHANNELS-1:0]       dout,
    output logic                      tick,
    output logic                      underrun
);
    localparam int EW = WIDTH + 3;

    localparam logic [WIDTH-1:0]     MIDSCALE   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [EW:0]   V_MAX      = {3'b000, {(WIDTH+1){1'b1}}};
    localparam logic signed [EW:0]   V_MIN      = {3'b111, {(WIDTH+1){1'b0}}};
    localparam logic signed [EW-1:0] Q_THRESH   = {3'b000, 1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [EW-1:0] FULL_SCALE = {3'b001, {WIDTH{1'b0}}};

    logic [OSR_LOG2-1:0]       cnt_reg;
    logic                      full_reg;
    logic                      order2_reg;
    logic [CHANNELS*WIDTH-1:0] buf_reg;
    logic                      accept;
    logic                      clear;
    logic [CHANNELS-1:0]       dith;

    assign tick     = (cnt_reg == {OSR_LOG2{1'b1}});
    assign underrun = tick & ~full_reg;
    assign s_ready  = ~full_reg;
    assign accept   = s_valid & ~full_reg;
    // A mode switch restarts every modulator from zero state on the following edge.
    assign clear    = order2 ^ order2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            full_reg   <= 1'b0;
            order2_reg <= 1'b0;
            buf_reg    <= '0;
        end else begin
            cnt_reg    <= cnt_reg + OSR_LOG2'(1);
            order2_reg <= order2;
            if (accept) begin
                buf_reg  <= s_data;
                full_reg <= 1'b1;
            end else if (tick) begin
                full_reg <= 1'b0;
            end
        end
    end

`ifdef SD_DAC_MC_DITHER_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= 16'hACE1;
        end else if (lfsr_reg[0]) begin
            lfsr_reg <= (lfsr_reg >> 1) ^ 16'hB400;
        end else begin
            lfsr_reg <= lfsr_reg >> 1;
        end
    end

    assign dith = lfsr_reg[CHANNELS-1:0];
`else
    assign dith = '0;
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0]     act_reg;
        logic [WIDTH-1:0]     acc_reg;
        logic signed [EW-1:0] e1_reg;
        logic signed [EW-1:0] e2_reg;
        logic                 dout_reg;
        logic [WIDTH:0]       sum;
        logic signed [EW:0]   v_raw;
        logic signed [EW-1:0] v_sat;
        logic signed [EW-1:0] e_next;
        logic                 q;

        assign sum = {1'b0, acc_reg} + {1'b0, act_reg} + {{WIDTH{1'b0}}, dith[gi]};

        // One extra bit of headroom so v = x + 2*e1 - e2 never wraps before saturation.
        assign v_raw = $signed({4'b0000, act_reg})
                     + ($signed({e1_reg[EW-1], e1_reg}) <<< 1)
                     - $signed({e2_reg[EW-1], e2_reg})
                     + $signed({{EW{1'b0}}, dith[gi]});

        assign v_sat  = (v_raw > V_MAX) ? V_MAX[EW-1:0] :
                        (v_raw < V_MIN) ? V_MIN[EW-1:0] : v_raw[EW-1:0];
        assign q      = (v_sat >= Q_THRESH);
        assign e_next = q ? (v_sat - FULL_SCALE) : v_sat;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_reg  <= MIDSCALE;
                acc_reg  <= '0;
                e1_reg   <= '0;
                e2_reg   <= '0;
                dout_reg <= 1'b0;
            end else begin
                if (tick && full_reg) begin
                    act_reg <= buf_reg[gi*WIDTH +: WIDTH];
                end
                if (clear) begin
                    acc_reg  <= '0;
                    e1_reg   <= '0;
                    e2_reg   <= '0;
                    dout_reg <= 1'b0;
                end else if (order2) begin
                    e2_reg   <= e1_reg;
                    e1_reg   <= e_next;
                    dout_reg <= q;
                end else begin
                    acc_reg  <= sum[WIDTH-1:0];
                    dout_reg <= sum[WIDTH];
                end
            end
        end

        assign dout[gi] = dout_reg;
    end

endmodule

// File: tb/tb_sd_dac_mc.sv
// Scoreboard bench for sd_dac_mc: an integer reference model predicts each sample period,
// a negedge monitor compares the DUT's dout history, underrun and s_ready at every tick.
module tb_sd_dac_mc;
    localparam int W    = 16;
    localparam int CH   = 2;
    localparam int OL   = 4;
    localparam int P    = 1 << OL;
    localparam int FS   = 1 << W;
    localparam int HALF = 1 << (W - 1);
    localparam int VHI  = (1 << (W + 1)) - 1;
    localparam int VLO  = -(1 << (W + 1));

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [CH*W-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          order2  = 1'b0;
    logic          s_ready;
    logic [CH-1:0] dout;
    logic          tick;
    logic          underrun;

    sd_dac_mc #(.WIDTH(W), .CHANNELS(CH), .OSR_LOG2(OL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .order2   (order2),
        .dout     (dout),
        .tick     (tick),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CH*P-1:0] pat;
        logic            empty;
    } exp_t;

    exp_t exp_q[$];
    int tests   = 0;
    int fails   = 0;
    int n_ticks = 0;

    // ---------------- reference model (integer arithmetic) ----------------
    int m_cnt;
    bit m_full;
    bit m_ordp;
    int m_buf[CH];
    int m_act[CH];
    int m_acc[CH];
    int m_e1[CH];
    int m_e2[CH];
    logic [CH*P-1:0] m_hist;

    task automatic model_reset();
        m_cnt  = 0;
        m_full = 1'b0;
        m_ordp = 1'b0;
        m_hist = '0;
        for (int c = 0; c < CH; c++) begin
            m_buf[c] = 0;
            m_act[c] = HALF;
            m_acc[c] = 0;
            m_e1[c]  = 0;
            m_e2[c]  = 0;
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        bit   tk   = (m_cnt == P - 1);
        bit   take = (s_valid === 1'b1) && !m_full;
        exp_t r;
        for (int c = 0; c < CH; c++) begin
            int x = m_act[c];
            int v;
            bit d = 1'b0;
            if (order2 != m_ordp) begin
                m_acc[c] = 0;
                m_e1[c]  = 0;
                m_e2[c]  = 0;
            end else if (!order2) begin
                v        = m_acc[c] + x;
                d        = (v >= FS);
                m_acc[c] = v % FS;
            end else begin
                v = x + 2 * m_e1[c] - m_e2[c];
                if (v > VHI) v = VHI;
                if (v < VLO) v = VLO;
                d       = (v >= HALF);
                m_e2[c] = m_e1[c];
                m_e1[c] = d ? v - FS : v;
            end
            m_hist[c*P +: P] = {m_hist[c*P +: P-1], d};
        end
        if (tk && m_full) begin
            for (int c = 0; c < CH; c++) m_act[c] = m_buf[c];
        end
        if (take) begin
            m_full = 1'b1;
            for (int c = 0; c < CH; c++) m_buf[c] = int'(s_data[c*W +: W]);
        end else if (tk) begin
            m_full = 1'b0;
        end
        m_ordp = order2;
        m_cnt  = (m_cnt + 1) % P;
        if (m_cnt == P - 1) begin
            r.pat   = m_hist;
            r.empty = !m_full;
            exp_q.push_back(r);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- monitor ----------------
    logic [CH*P-1:0] mon_hist;

    task automatic monitor_tick();
        exp_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL tick_unexpected: tick=%b, required no tick in this cycle", tick);
        end else begin
            e = exp_q.pop_front();
            n_ticks++;
            if (tick !== 1'b1) begin
                fails++;
                $display("FAIL tick_missing: tick=%b, required 1 (period %0d)", tick, n_ticks);
            end else begin
                tests++;
                if (mon_hist !== e.pat) begin
                    fails++;
                    $display("FAIL dout_pattern: period %0d got %h, required %h", n_ticks, mon_hist, e.pat);
                end
                tests++;
                if (underrun !== e.empty) begin
                    fails++;
                    $display("FAIL underrun: period %0d got %b, required %b", n_ticks, underrun, e.empty);
                end
                tests++;
                if (s_ready !== e.empty) begin
                    fails++;
                    $display("FAIL s_ready_at_tick: period %0d got %b, required %b", n_ticks, s_ready, e.empty);
                end
                $display("[TB] tick %0d dout_hist=%h expected=%h underrun=%b s_ready=%b",
                         n_ticks, mon_hist, e.pat, underrun, s_ready);
            end
        end
    endtask

    initial begin
        mon_hist = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_hist = '0;
                tests++;
                if (dout !== '0 || tick !== 1'b0 || underrun !== 1'b0 || s_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL reset_state: dout=%b tick=%b underrun=%b s_ready=%b, required 0 0 0 1",
                             dout, tick, underrun, s_ready);
                end
            end else begin
                for (int c = 0; c < CH; c++) mon_hist[c*P +: P] = {mon_hist[c*P +: P-1], dout[c]};
                if (tick === 1'b1 || exp_q.size() > 0) monitor_tick();
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic send_frame(input int x0, input int x1, input bit keep_valid);
        bit done = 1'b0;
        s_data  = {W'(x1), W'(x0)};
        s_valid = 1'b1;
        for (int i = 0; i < 4 * P && !done; i++) begin
            bit r = s_ready;
            step(1);
            if (r) done = 1'b1;
        end
        check("accept_within_budget", int'(done), 1);
        if (!keep_valid) s_valid = 1'b0;
    endtask

    task automatic wait_tick(output bit und, output int cyc);
        cyc = 0;
        while (tick !== 1'b1 && cyc < 2 * P) begin
            step(1);
            cyc++;
        end
        check("tick_within_budget", int'(tick === 1'b1), 1);
        und = underrun;
        step(1);
    endtask

    task automatic count_ones(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < n; i++) begin
            step(1);
            c0 += int'(dout[0]);
            c1 += int'(dout[1]);
        end
    endtask

    function automatic int pick_x();
        int sel = int'($urandom_range(0, 3));
        if (sel == 0) return 0;
        if (sel == 1) return FS - 1;
        return int'($urandom_range(0, FS - 1));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        bit und;
        int cyc;
        int c0;
        int c1;

        step(3);
        rst_n = 1'b1;

        // One frame then starvation: load at first tick, underrun at the second.
        send_frame(16'h4000, 16'h4000, 1'b0);
        wait_tick(und, cyc);
        check("underrun_first_tick", int'(und), 0);
        wait_tick(und, cyc);
        check("underrun_second_tick", int'(und), 1);
        check("tick_period", cyc + 1, P);
        count_ones(64, c0, c1);
        check("ones_x4000_ch0", c0, 16);
        check("ones_x4000_ch1", c1, 16);

        // Zero input stays silent in both modes, including across a mode switch.
        send_frame(0, 0, 1'b0);
        wait_tick(und, cyc);
        count_ones(32, c0, c1);
        check("ones_x0_first_order", c0 + c1, 0);
        order2 = 1'b1;
        step(1);
        check("dout_after_mode_switch", int'(dout), 0);
        count_ones(64, c0, c1);
        check("ones_x0_second_order", c0 + c1, 0);

        // Second-order midscale density.
        send_frame(16'h8000, 16'h8000, 1'b0);
        wait_tick(und, cyc);
        count_ones(256, c0, c1);
        check_range("ones_2nd_mid_ch0", c0, 126, 130);
        check_range("ones_2nd_mid_ch1", c1, 126, 130);

        // Back-to-back frames with s_valid held high.
        order2 = 1'b0;
        send_frame(16'h1000, 16'h1000, 1'b1);
        check("s_ready_low_after_accept_1", int'(s_ready), 0);
        send_frame(16'h2000, 16'h2000, 1'b1);
        check("s_ready_low_after_accept_2", int'(s_ready), 0);
        send_frame(16'h3000, 16'h3000, 1'b1);
        check("s_ready_low_after_accept_3", int'(s_ready), 0);
        s_valid = 1'b0;
        wait_tick(und, cyc);
        check("underrun_chain_load", int'(und), 0);
        count_ones(64, c0, c1);
        check("ones_x3000_ch0", c0, 12);
        check("ones_x3000_ch1", c1, 12);

        // Reset in the middle of a full-scale frame with another frame buffered.
        send_frame(16'hFFFF, 16'hFFFF, 1'b0);
        wait_tick(und, cyc);
        step(5);
        send_frame(16'h1234, 16'h1234, 1'b0);
        rst_n = 1'b0;
        #1;
        check("dout_in_reset", int'(dout), 0);
        check("s_ready_in_reset", int'(s_ready), 1);
        step(1);
        rst_n = 1'b1;
        count_ones(64, c0, c1);
        check("ones_midscale_after_reset_ch0", c0, 32);
        check("ones_midscale_after_reset_ch1", c1, 32);

        // Randomized traffic, mode switches and short resets.
        for (int i = 0; i < 2000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = {W'(pick_x()), W'(pick_x())};
            if ($urandom_range(0, 149) == 0) order2 = ~order2;
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            step(1);
        end
        s_valid = 1'b0;
        step(2 * P);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
